// File: rtl/pll_reset_sequencer_if.sv
// Avalon-MM CSR port of the PLL reset sequencer.
interface pll_reset_sequencer_if;
  logic        avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a lock verdict from the
// monitor, retries a bounded number of times, and releases the downstream
// reset only while lock is held.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// HOLD        | software hold; PLL kept in reset until hold clears
// ASSERT_RST  | reset request high for RESET_PULSE_CYCLES
// BLANK       | request low, monitor flags ignored (stale results)
// WAIT_RESULT | waiting for success / failure / timeout
// LOCKED      | lock good, downstream reset released one cycle after entry
// FAILED      | retry budget exhausted; only a CSR restart leaves
module pll_reset_sequencer #(
  parameter int unsigned RESET_PULSE_CYCLES = 16,
  parameter int unsigned BLANK_CYCLES       = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 4096,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lock_success,
  input  logic lock_failure,
  output logic pll_reset_request,
  output logic downstream_reset_n,
  output logic seq_failed,
  pll_reset_sequencer_if.slave avs
);

  typedef enum logic [2:0] {
    S_HOLD        = 3'd0,
    S_ASSERT_RST  = 3'd1,
    S_BLANK       = 3'd2,
    S_WAIT_RESULT = 3'd3,
    S_LOCKED      = 3'd4,
    S_FAILED      = 3'd5
  } state_t;

  // One shared phase counter covers the pulse, blanking and timeout phases.
  localparam int unsigned MAX_A = (RESET_PULSE_CYCLES > BLANK_CYCLES) ? RESET_PULSE_CYCLES : BLANK_CYCLES;
  localparam int unsigned MAX_L = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_L + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       ATTEMPT_MAX  = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       attempt_q, attempt_d;
  logic [7:0]       loss_q, loss_d;
  logic             hold_q, hold_d;
  logic             dsr_q, dsr_d;
  logic [31:0]      rdata_q, rdata_d;

  logic ctrl_wr;
  logic restart;
  logic clear_loss;
  logic loss_event;
  logic wdata_unused;

  assign ctrl_wr      = avs.avs_write & avs.avs_address;
  assign restart      = ctrl_wr & avs.avs_writedata[0];
  assign clear_loss   = ctrl_wr & avs.avs_writedata[2];
  assign wdata_unused = ^avs.avs_writedata[31:3];

  // Sequencer next-state: restart overrides any monitor event.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    attempt_d  = attempt_q;
    loss_event = 1'b0;
    case (state_q)
      S_HOLD: begin
        cnt_d = '0;
        if (!hold_q) state_d = S_ASSERT_RST;
      end
      S_ASSERT_RST: begin
        if (hold_q) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == PULSE_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = S_WAIT_RESULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_RESULT: begin
        if (lock_success) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else if (lock_failure || (cnt_q == TIMEOUT_LAST)) begin
          cnt_d = '0;
          if (attempt_q == ATTEMPT_MAX) begin
            state_d = S_FAILED;
          end else begin
            state_d   = S_ASSERT_RST;
            attempt_d = attempt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LOCKED: begin
        cnt_d = '0;
        if (lock_failure) begin
          state_d    = S_ASSERT_RST;
          attempt_d  = '0;
          loss_event = 1'b1;
        end
      end
      S_FAILED: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_ASSERT_RST;
        cnt_d   = '0;
      end
    endcase

    if (restart) begin
      state_d    = S_ASSERT_RST;
      cnt_d      = '0;
      attempt_d  = '0;
      loss_event = 1'b0;
    end
  end

  // CSR side: hold bit, loss counter, registered read data, downstream reset.
  always_comb begin
    hold_d = hold_q;
    if (ctrl_wr) hold_d = avs.avs_writedata[1];

    loss_d = loss_q;
    if (clear_loss)                        loss_d = '0;
    else if (loss_event && loss_q != 8'hFF) loss_d = loss_q + 8'd1;

    rdata_d = rdata_q;
    if (avs.avs_read) begin
      if (avs.avs_address)
        rdata_d = {29'd0, 1'b0, hold_q, 1'b0};
      else
        rdata_d = {13'd0, hold_q, (state_q == S_FAILED), (state_q == S_LOCKED),
                   loss_q, attempt_q, 1'b0, state_q};
    end

    // Release only once LOCKED is already registered, and drop on the same
    // edge that leaves LOCKED.
    dsr_d = (state_q == S_LOCKED) && (state_d == S_LOCKED);
  end

  // State and CSR registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_ASSERT_RST;
      cnt_q     <= '0;
      attempt_q <= '0;
      loss_q    <= '0;
      hold_q    <= 1'b0;
      dsr_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      attempt_q <= attempt_d;
      loss_q    <= loss_d;
      hold_q    <= hold_d;
      dsr_q     <= dsr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign pll_reset_request  = (state_q == S_ASSERT_RST) || (state_q == S_HOLD);
  assign downstream_reset_n = dsr_q;
  assign seq_failed         = (state_q == S_FAILED);
  assign avs.avs_readdata   = rdata_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controller for the PLL reset monitor. Drives the PLL reset request and interprets the monitor's lock_success / lock_failure results.
- Retries failed lock attempts up to a fixed budget, then releases a downstream reset once lock is good. On loss of lock it re-asserts that reset and restarts the sequence.
- Sits between the monitor and downstream logic. Exposes a small Avalon-MM CSR for status and software restart/hold.

Parameters:
- RESET_PULSE_CYCLES, 16: cycles pll_reset_request is held high per attempt (min 1).
- BLANK_CYCLES, 4: cycles after the request drops during which monitor flags are ignored (clears stale results).
- TIMEOUT_CYCLES, 4096: cycles to wait for any monitor result before the attempt counts as failed.
- MAX_RETRIES, 3: failed attempts allowed before FAILED; total attempts = MAX_RETRIES+1.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset; asynchronous assert, synchronous deassert handled upstream.
- lock_success  in  1  monitor level: lock qualified.
- lock_failure  in  1  monitor level: lock not achieved or lost.
- pll_reset_request  out  1  active-high reset request to PLL and monitor.
- downstream_reset_n  out  1  active-low reset for PLL-clocked consumers.
- seq_failed  out  1  high in FAILED.
- avs_address  in  1  CSR word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid exactly 1 cycle after avs_read; no waitrequest.

Behaviour:
- Reset values: state=ASSERT_RST, pll_reset_request=1, downstream_reset_n=0, seq_failed=0, attempt=0, loss_count=0, hold=0, avs_readdata=0, all counters 0.
- States: HOLD, ASSERT_RST, BLANK, WAIT_RESULT, LOCKED, FAILED. Encoding for status is 0..5 in that order.
- ASSERT_RST:
  - pll_reset_request=1 for exactly RESET_PULSE_CYCLES cycles, then go to BLANK.
  - If hold=1, go to HOLD instead (pll_reset_request stays 1 in HOLD).
- BLANK: request=0; flags ignored for BLANK_CYCLES cycles, then WAIT_RESULT with the timeout counter cleared.
- WAIT_RESULT, evaluated in priority order:
  - lock_success=1 → LOCKED. If both flags are high in the same cycle, success wins.
  - lock_failure=1, or timeout counter reaches TIMEOUT_CYCLES-1 → failed attempt:
    - if attempt==MAX_RETRIES → FAILED;
    - else attempt+1, back to ASSERT_RST.
- LOCKED:
  - downstream_reset_n=1, registered and asserted the cycle after entry.
  - lock_failure=1 → downstream_reset_n=0 in the next cycle, loss_count+1 (8-bit, saturating at 255), attempt=0, go to ASSERT_RST.
  - lock_success dropping alone with no failure is ignored.
- FAILED: request=0, downstream_reset_n=0, seq_failed=1. Leaves only on CSR restart.
- HOLD: request=1, downstream_reset_n=0. Leaves to ASSERT_RST (fresh pulse count) when hold clears.
- downstream_reset_n is 0 in every state except LOCKED.
- CSR address 0, status, read-only:
  - [2:0] state
  - [7:4] attempt
  - [15:8] loss_count
  - [16] LOCKED
  - [17] FAILED
  - [18] hold
  - other bits 0
- CSR address 1, control:
  - write bit0=1 → restart from any state: attempt=0, go to ASSERT_RST next cycle. Self-clearing; reads as 0.
  - bit1 = hold, read/write.
  - bit2 write-1 clears loss_count.
  - If restart and clear are written together, both take effect.
- Simultaneous CSR restart and a monitor event: restart wins.
- Reads of address 0 return the value sampled on the avs_read cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). hold clears.

Test Plan:
- Lock on first attempt: release reset_n, raise lock_success 50 cycles after the request falls → request high exactly 16 cycles; downstream_reset_n=1 one cycle after LOCKED; status reads 0x00010004.
- Retries exhausted: drive lock_failure after every BLANK → 4 request pulses total, then seq_failed=1, downstream_reset_n=0, status 0x00020035.
- Timeout: both flags held 0 → attempt increments every 16+4+4096 cycles; FAILED after 4 attempts.
- Loss of lock: from LOCKED pulse lock_failure for 1 cycle → downstream_reset_n=0 next cycle; loss_count=1; new 16-cycle request; relock gives status 0x00010104.
- CSR control:
  - write 0x2 → HOLD, request stays 1;
  - write 0x0 → fresh 16-cycle pulse;
  - in FAILED write 0x5 → attempt=0, loss_count=0, restarts.
- Stale/simultaneous flags: lock_success high during BLANK → ignored; both flags high in WAIT_RESULT → LOCKED; reset_n asserted mid-WAIT_RESULT → all outputs return to reset values within the same cycle.
